combat_referee: RTL and testbench

//  Round controller and hit arbiter for the two-player fighter. Sits above both player

---
 rtl/combat_pkg.sv | 53 +++++
 rtl/hitstun_timer.sv | 43 ++++
 rtl/combat_referee.sv | 203 ++++++++++++++++++++
 tb/tb_combat_referee.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
// Shared encodings, geometry constants and winner helpers for the fighter round referee.
package combat_pkg;

    typedef enum logic [1:0] {
        PH_COUNTDOWN = 2'd0,
        PH_FIGHT     = 2'd1,
        PH_KO        = 2'd2,
        PH_OVER      = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    localparam int SPRITE_W = 64;
    localparam int HEALTH_W = 3;
    localparam int DIST_W   = 11;

    function automatic logic [HEALTH_W-1:0] health_dec(input logic [HEALTH_W-1:0] h);
        return (h == {HEALTH_W{1'b0}}) ? h : h - {{(HEALTH_W-1){1'b0}}, 1'b1};
    endfunction

    // Called only once at least one health has reached zero.
    function automatic winner_e ko_winner(input logic [HEALTH_W-1:0] p1_h,
                                          input logic [HEALTH_W-1:0] p2_h);
        winner_e w;
        if ((p1_h == {HEALTH_W{1'b0}}) && (p2_h == {HEALTH_W{1'b0}})) begin
            w = WIN_DRAW;
        end else if (p2_h == {HEALTH_W{1'b0}}) begin
            w = WIN_P1;
        end else begin
            w = WIN_P2;
        end
        return w;
    endfunction

    function automatic winner_e timeout_winner(input logic [HEALTH_W-1:0] p1_h,
                                               input logic [HEALTH_W-1:0] p2_h);
        winner_e w;
        if (p1_h > p2_h) begin
            w = WIN_P1;
        end else if (p2_h > p1_h) begin
            w = WIN_P2;
        end else begin
            w = WIN_DRAW;
        end
        return w;
    endfunction

endpackage

// File: rtl/hitstun_timer.sv
// Per-player hitstun down-counter: loads on a hit, counts down on frame ticks, busy while nonzero.
module hitstun_timer #(
    parameter int FRAMES = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic load_i,
    input  logic clear_i,
    output logic busy_o
);

    localparam int CNT_W = $clog2(FRAMES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats load beats the per-tick decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (tick_i && load_i) begin
            cnt_d = CNT_W'(FRAMES);
        end else if (tick_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/combat_referee.sv
// Round controller and hit arbiter for the two-player fighter.
// Optional fight time limit is built in when ROUND_TIMER_EN is defined.
module combat_referee
    import combat_pkg::*;
#(
    parameter int REACH            = 32,
    parameter int HEALTH_MAX       = 3,
    parameter int HITSTUN_FRAMES   = 12,
    parameter int COUNTDOWN_FRAMES = 180,
`ifdef ROUND_TIMER_EN
    parameter int ROUND_FRAMES     = 5940,
`endif
    parameter int KO_HOLD_FRAMES   = 120
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic [9:0]          p1_x,
    input  logic [9:0]          p2_x,
    input  logic                p1_active,
    input  logic                p2_active,
    output logic                p1_en,
    output logic                p2_en,
    output logic                p1_stun,
    output logic                p2_stun,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [1:0]          phase,
    output logic [1:0]          winner,
    output logic [1:0]          hit_pulse,
    output logic [6:0]          round_secs
);

    localparam int PH_CNT_MAX = (COUNTDOWN_FRAMES > KO_HOLD_FRAMES) ? COUNTDOWN_FRAMES : KO_HOLD_FRAMES;
    localparam int PH_CNT_W   = $clog2(PH_CNT_MAX + 1);

    phase_e                phase_q, phase_d;
    winner_e               winner_q, winner_d;
    logic [PH_CNT_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [HEALTH_W-1:0]   p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0]   p2_health_q, p2_health_d;
    logic                  p1_done_q, p1_done_d;
    logic                  p2_done_q, p2_done_d;
    logic [1:0]            hit_pulse_q, hit_pulse_d;

    logic [DIST_W-1:0]     p1_front_s;
    logic [DIST_W-1:0]     p2_left_s;
    logic [DIST_W-1:0]     dist_s;
    logic                  in_range_s;
    logic                  p1_hits_s, p2_hits_s;
    logic                  p1_stun_s, p2_stun_s;
    logic                  stun_clear_s;

`ifdef ROUND_TIMER_EN
    localparam int RND_W = $clog2(ROUND_FRAMES + 1);
    logic [RND_W-1:0]      round_q, round_d;
`endif

    // Gap between P1's front edge and P2's left edge; overlapping sprites count as zero.
    assign p1_front_s = {1'b0, p1_x} + DIST_W'(SPRITE_W);
    assign p2_left_s  = {1'b0, p2_x};
    assign dist_s     = (p2_left_s > p1_front_s) ? (p2_left_s - p1_front_s) : {DIST_W{1'b0}};
    assign in_range_s = (dist_s <= DIST_W'(REACH));

    assign p1_hits_s = (phase_q == PH_FIGHT) & p1_active & in_range_s & ~p1_done_q & ~p2_stun_s;
    assign p2_hits_s = (phase_q == PH_FIGHT) & p2_active & in_range_s & ~p2_done_q & ~p1_stun_s;

    assign stun_clear_s = (phase_d == PH_KO) || (phase_d == PH_OVER);

    hitstun_timer #(.FRAMES(HITSTUN_FRAMES)) u_p1_stun (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (frame_tick),
        .load_i  (p2_hits_s),
        .clear_i (stun_clear_s),
        .busy_o  (p1_stun_s)
    );

    hitstun_timer #(.FRAMES(HITSTUN_FRAMES)) u_p2_stun (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (frame_tick),
        .load_i  (p1_hits_s),
        .clear_i (stun_clear_s),
        .busy_o  (p2_stun_s)
    );

    // Next-state: hit resolution, health, and round phase sequencing on each frame tick.
    always_comb begin
        phase_d     = phase_q;
        winner_d    = winner_q;
        ph_cnt_d    = ph_cnt_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_done_d   = p1_done_q;
        p2_done_d   = p2_done_q;
        hit_pulse_d = 2'b00;
`ifdef ROUND_TIMER_EN
        round_d     = round_q;
`endif
        if (frame_tick) begin
            hit_pulse_d = {p2_hits_s, p1_hits_s};
            // Done latches the current swing and releases once the attack goes inactive.
            p1_done_d   = p1_active & (p1_done_q | p1_hits_s);
            p2_done_d   = p2_active & (p2_done_q | p2_hits_s);
            p1_health_d = p2_hits_s ? health_dec(p1_health_q) : p1_health_q;
            p2_health_d = p1_hits_s ? health_dec(p2_health_q) : p2_health_q;
            case (phase_q)
                PH_COUNTDOWN: begin
                    if (ph_cnt_q == PH_CNT_W'(COUNTDOWN_FRAMES - 1)) begin
                        phase_d  = PH_FIGHT;
                        ph_cnt_d = {PH_CNT_W{1'b0}};
`ifdef ROUND_TIMER_EN
                        round_d  = RND_W'(ROUND_FRAMES);
`endif
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_CNT_W'(1);
                    end
                end
                PH_FIGHT: begin
`ifdef ROUND_TIMER_EN
                    round_d = (round_q != {RND_W{1'b0}}) ? round_q - RND_W'(1) : round_q;
`endif
                    if ((p1_health_d == {HEALTH_W{1'b0}}) || (p2_health_d == {HEALTH_W{1'b0}})) begin
                        phase_d  = PH_KO;
                        winner_d = ko_winner(p1_health_d, p2_health_d);
                        ph_cnt_d = {PH_CNT_W{1'b0}};
`ifdef ROUND_TIMER_EN
                    end else if (round_q <= RND_W'(1)) begin
                        phase_d  = PH_KO;
                        winner_d = timeout_winner(p1_health_d, p2_health_d);
                        ph_cnt_d = {PH_CNT_W{1'b0}};
`endif
                    end else begin
                        phase_d = PH_FIGHT;
                    end
                end
                PH_KO: begin
                    if (ph_cnt_q == PH_CNT_W'(KO_HOLD_FRAMES - 1)) begin
                        phase_d  = PH_OVER;
                        ph_cnt_d = {PH_CNT_W{1'b0}};
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_CNT_W'(1);
                    end
                end
                PH_OVER: begin
                    phase_d = PH_OVER;
                end
                default: begin
                    phase_d  = PH_COUNTDOWN;
                    ph_cnt_d = {PH_CNT_W{1'b0}};
                end
            endcase
        end else begin
            hit_pulse_d = 2'b00;
        end
    end

    // State registers; reset aborts the round from any phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_COUNTDOWN;
            winner_q    <= WIN_NONE;
            ph_cnt_q    <= {PH_CNT_W{1'b0}};
            p1_health_q <= HEALTH_W'(HEALTH_MAX);
            p2_health_q <= HEALTH_W'(HEALTH_MAX);
            p1_done_q   <= 1'b0;
            p2_done_q   <= 1'b0;
            hit_pulse_q <= 2'b00;
`ifdef ROUND_TIMER_EN
            round_q     <= {RND_W{1'b0}};
`endif
        end else begin
            phase_q     <= phase_d;
            winner_q    <= winner_d;
            ph_cnt_q    <= ph_cnt_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_done_q   <= p1_done_d;
            p2_done_q   <= p2_done_d;
            hit_pulse_q <= hit_pulse_d;
`ifdef ROUND_TIMER_EN
            round_q     <= round_d;
`endif
        end
    end

    assign p1_en     = (phase_q == PH_FIGHT) & ~p1_stun_s;
    assign p2_en     = (phase_q == PH_FIGHT) & ~p2_stun_s;
    assign p1_stun   = p1_stun_s;
    assign p2_stun   = p2_stun_s;
    assign p1_health = p1_health_q;
    assign p2_health = p2_health_q;
    assign phase     = phase_q;
    assign winner    = winner_q;
    assign hit_pulse = hit_pulse_q;
`ifdef ROUND_TIMER_EN
    assign round_secs = 7'(round_q / RND_W'(60));
`else
    assign round_secs = 7'd0;
`endif

endmodule

// File: tb/tb_combat_referee.sv
// Directed self-checking bench for combat_referee: countdown, hits, range limits, trade, KO, reset.
module tb_combat_referee;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [9:0] p1_x, p2_x;
    logic       p1_active, p2_active;
    logic       p1_en, p2_en, p1_stun, p2_stun;
    logic [2:0] p1_health, p2_health;
    logic [1:0] phase, winner, hit_pulse;
    logic [6:0] round_secs;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] pulse_seen;

    combat_referee dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .p1_x       (p1_x),
        .p2_x       (p2_x),
        .p1_active  (p1_active),
        .p2_active  (p2_active),
        .p1_en      (p1_en),
        .p2_en      (p2_en),
        .p1_stun    (p1_stun),
        .p2_stun    (p2_stun),
        .p1_health  (p1_health),
        .p2_health  (p2_health),
        .phase      (phase),
        .winner     (winner),
        .hit_pulse  (hit_pulse),
        .round_secs (round_secs)
    );

    always #5 clk = ~clk;

    // One frame tick: strobe for one cycle, capture hit_pulse in the cycle after the edge.
    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        pulse_seen = hit_pulse;
        @(posedge clk); #1;
    endtask

    task automatic restart();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (180) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b0;
        p1_x = 10'd100; p2_x = 10'd190; p1_active = 1'b0; p2_active = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        checks++; if (p1_health !== 3'd3 || p2_health !== 3'd3) begin errors++; $display("FAIL reset_health: got %0d/%0d expected 3/3", p1_health, p2_health); end
        checks++; if ({p1_en, p2_en, p1_stun, p2_stun} !== 4'b0000) begin errors++; $display("FAIL reset_en_stun: got %b expected 0000", {p1_en, p2_en, p1_stun, p2_stun}); end
        checks++; if (winner !== 2'd0 || hit_pulse !== 2'b00) begin errors++; $display("FAIL reset_winner_pulse: got %0d/%b expected 0/00", winner, hit_pulse); end
    endtask

    task automatic test_countdown();
        repeat (179) tick();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL countdown_179: got phase %0d expected 0", phase); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL countdown_idle: got phase %0d expected 0", phase); end
        tick();
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL countdown_180: got phase %0d expected 1", phase); end
        checks++; if (p1_en !== 1'b1 || p2_en !== 1'b1) begin errors++; $display("FAIL fight_en: got %b%b expected 11", p1_en, p2_en); end
`ifdef ROUND_TIMER_EN
        checks++; if (round_secs !== 7'd99) begin errors++; $display("FAIL round_secs_start: got %0d expected 99", round_secs); end
`else
        checks++; if (round_secs !== 7'd0) begin errors++; $display("FAIL round_secs_zero: got %0d expected 0", round_secs); end
`endif
    endtask

    task automatic test_single_hit();
        int n;
        p1_x = 10'd100; p2_x = 10'd190; p1_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b01) begin errors++; $display("FAIL hit_pulse: got %b expected 01", pulse_seen); end
        checks++; if (hit_pulse !== 2'b00) begin errors++; $display("FAIL hit_pulse_width: got %b expected 00", hit_pulse); end
        checks++; if (p2_health !== 3'd2 || p1_health !== 3'd3) begin errors++; $display("FAIL hit_health: got %0d/%0d expected 3/2", p1_health, p2_health); end
        checks++; if (p2_stun !== 1'b1 || p2_en !== 1'b0 || p1_en !== 1'b1) begin errors++; $display("FAIL hit_stun: got stun=%b en=%b%b expected 1 en=10", p2_stun, p1_en, p2_en); end
        tick();
        checks++; if (pulse_seen !== 2'b00 || p2_health !== 3'd2) begin errors++; $display("FAIL one_hit_per_attack: got %b/%0d expected 00/2", pulse_seen, p2_health); end
        p1_active = 1'b0;
        n = 1;
        for (int i = 0; i < 30 && p2_en === 1'b0; i++) begin
            tick();
            n++;
        end
        checks++; if (n !== 12) begin errors++; $display("FAIL hitstun_len: got %0d ticks expected 12", n); end
    endtask

    task automatic test_out_of_range();
        p2_x = 10'd200; p1_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b00) begin errors++; $display("FAIL dist36_pulse: got %b expected 00", pulse_seen); end
        p1_active = 1'b0; tick();
        p2_x = 10'd197; p1_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b00) begin errors++; $display("FAIL dist33_pulse: got %b expected 00", pulse_seen); end
        p1_active = 1'b0; tick();
        checks++; if (p2_health !== 3'd2 || p1_health !== 3'd3) begin errors++; $display("FAIL miss_health: got %0d/%0d expected 3/2", p1_health, p2_health); end
    endtask

    task automatic test_trade();
        restart();
        p1_x = 10'd100; p2_x = 10'd150; p1_active = 1'b1; p2_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b11) begin errors++; $display("FAIL trade_pulse: got %b expected 11", pulse_seen); end
        checks++; if (p1_health !== 3'd2 || p2_health !== 3'd2) begin errors++; $display("FAIL trade_health: got %0d/%0d expected 2/2", p1_health, p2_health); end
        checks++; if (p1_stun !== 1'b1 || p2_stun !== 1'b1) begin errors++; $display("FAIL trade_stun: got %b%b expected 11", p1_stun, p2_stun); end
        p1_active = 1'b0; p2_active = 1'b0;
        repeat (12) tick();
        checks++; if (p1_stun !== 1'b0 || p2_stun !== 1'b0) begin errors++; $display("FAIL trade_unstun: got %b%b expected 00", p1_stun, p2_stun); end
    endtask

    task automatic test_stun_blocks();
        p1_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b01 || p2_health !== 3'd1) begin errors++; $display("FAIL second_hit: got %b/%0d expected 01/1", pulse_seen, p2_health); end
        p1_active = 1'b0; tick();
        p1_active = 1'b1; tick();
        checks++; if (pulse_seen !== 2'b00 || p2_health !== 3'd1) begin errors++; $display("FAIL stunned_defender: got %b/%0d expected 00/1", pulse_seen, p2_health); end
        p1_active = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_ko();
        p2_x = 10'd196; p1_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b01 || p2_health !== 3'd0) begin errors++; $display("FAIL reach_edge_hit: got %b/%0d expected 01/0", pulse_seen, p2_health); end
        checks++; if (phase !== 2'd2 || winner !== 2'd1) begin errors++; $display("FAIL ko_enter: got phase %0d winner %0d expected 2/1", phase, winner); end
        checks++; if ({p1_en, p2_en, p1_stun, p2_stun} !== 4'b0000) begin errors++; $display("FAIL ko_en_stun: got %b expected 0000", {p1_en, p2_en, p1_stun, p2_stun}); end
        p1_active = 1'b0;
        repeat (119) tick();
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL ko_hold: got phase %0d expected 2", phase); end
        tick();
        checks++; if (phase !== 2'd3) begin errors++; $display("FAIL over: got phase %0d expected 3", phase); end
        p2_x = 10'd150; p1_active = 1'b1; p2_active = 1'b1;
        tick();
        checks++; if (pulse_seen !== 2'b00 || p1_health !== 3'd2 || phase !== 2'd3 || winner !== 2'd1) begin
            errors++; $display("FAIL over_ignores: got pulse %b p1h %0d phase %0d winner %0d expected 00/2/3/1", pulse_seen, p1_health, phase, winner);
        end
        p1_active = 1'b0; p2_active = 1'b0;
    endtask

    task automatic test_reset_in_ko();
        restart();
        p1_x = 10'd100; p2_x = 10'd190;
        for (int k = 0; k < 3; k++) begin
            p1_active = 1'b1; tick();
            p1_active = 1'b0; repeat (13) tick();
        end
        checks++; if (phase !== 2'd2 || winner !== 2'd1 || p2_health !== 3'd0) begin errors++; $display("FAIL three_hits_ko: got phase %0d winner %0d p2h %0d expected 2/1/0", phase, winner, p2_health); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (phase !== 2'd0 || winner !== 2'd0 || p1_health !== 3'd3 || p2_health !== 3'd3) begin
            errors++; $display("FAIL reset_in_ko: got phase %0d winner %0d health %0d/%0d expected 0/0/3/3", phase, winner, p1_health, p2_health);
        end
    endtask

`ifdef ROUND_TIMER_EN
    task automatic test_round_timer();
        int n;
        restart();
        p1_x = 10'd100; p2_x = 10'd190; p1_active = 1'b1;
        tick();
        p1_active = 1'b0;
        n = 1;
        for (int i = 0; i < 7000 && phase === 2'd1; i++) begin
            tick();
            n++;
        end
        checks++; if (n !== 5940) begin errors++; $display("FAIL timer_len: got %0d ticks expected 5940", n); end
        checks++; if (phase !== 2'd2 || winner !== 2'd1) begin errors++; $display("FAIL timer_winner: got phase %0d winner %0d expected 2/1", phase, winner); end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_single_hit();
        test_out_of_range();
        test_trade();
        test_stun_blocks();
        test_ko();
        test_reset_in_ko();
`ifdef ROUND_TIMER_EN
        test_round_timer();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
